// File: rtl/arb2_rr_addsched.sv
// ---------------------------------------------------------------------------
// arb2_rr_addsched
//
// Round-robin scheduler that shares one WIDTH-bit adder between two
// requesters. A winner is chosen in IDLE, granted for one cycle (READ),
// and its operand sum is captured into y at the end of READ. The sum is
// then presented with a one-cycle ack (WRITE). One operation completes
// every three cycles.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous active-low reset
//   r0, a0, b0  requester 0 request and operands (held until ack0)
//   r1, a1, b1  requester 1 request and operands (held until ack1)
//   g0, g1      registered grant, high only during READ
//   ack0, ack1  registered one-cycle result strobe, high only during WRITE
//   y           result register, holds until the next capture
//   busy        high during READ and WRITE
// ---------------------------------------------------------------------------
module arb2_rr_addsched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             r1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             g0,
    output logic             g1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t state;
    logic   sel;
    logic   last;
    logic   pick;

    // Arbitration choice for the current IDLE cycle: a lone requester wins
    // outright, and on a tie the requester that was not served last wins.
    always_comb begin
        pick = 1'b0;
        if (r0 && r1) begin
            pick = ~last;
        end else begin
            pick = r1;
        end
    end

    // Sequencer. Grants, acks and busy are set one state ahead so that
    // they come straight from flops and never glitch. The pointer starts
    // at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            g0    <= 1'b0;
            g1    <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= 1'b0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (r0 || r1) begin
                        sel   <= pick;
                        g0    <= ~pick;
                        g1    <= pick;
                        busy  <= 1'b1;
                        state <= READ;
                    end else begin
                        g0   <= 1'b0;
                        g1   <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                READ: begin
                    // Operands are sampled here, at the edge ending READ;
                    // the sum wraps and any carry out is discarded.
                    g0    <= 1'b0;
                    g1    <= 1'b0;
                    ack0  <= ~sel;
                    ack1  <= sel;
                    busy  <= 1'b1;
                    y     <= sel ? (a1 + b1) : (a0 + b0);
                    state <= WRITE;
                end
                WRITE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    last  <= sel;
                    state <= IDLE;
                end
                default: begin
                    g0    <= 1'b0;
                    g1    <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb2_rr_addsched.sv
// ---------------------------------------------------------------------------
// tb_arb2_rr_addsched
//
// Self-checking bench for arb2_rr_addsched. A transaction-level model
// tracks when the shared adder is free, who wins, and when each result
// must appear; every cycle the DUT outputs are compared against it.
// Directed scenarios pin the model with hand-computed values, then a
// randomized phase exercises arbitration, protocol violations and resets.
// ---------------------------------------------------------------------------
module tb_arb2_rr_addsched;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         r0    = 1'b0;
    logic         r1    = 1'b0;
    logic [W-1:0] a0    = '0;
    logic [W-1:0] b0    = '0;
    logic [W-1:0] a1    = '0;
    logic [W-1:0] b1    = '0;
    logic         g0, g1, ack0, ack1, busy;
    logic [W-1:0] y;

    int total = 0;
    int bad   = 0;
    bit checkOn = 1'b0;

    // Model state: edge counter, edge at which the winner's operands are
    // captured, first edge at which a new arbitration may happen.
    int cyc;
    int captureAt;
    int freeAt;
    bit who;
    bit lastServed;
    bit mG0, mG1, mAck0, mAck1, mBusy;
    int mY;

    arb2_rr_addsched #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .r0   (r0),
        .a0   (a0),
        .b0   (b0),
        .r1   (r1),
        .a1   (a1),
        .b1   (b1),
        .g0   (g0),
        .g1   (g1),
        .ack0 (ack0),
        .ack1 (ack1),
        .y    (y),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic nr0, input logic [W-1:0] na0, input logic [W-1:0] nb0,
                                 input logic nr1, input logic [W-1:0] na1, input logic [W-1:0] nb1);
        r0 = nr0;
        a0 = na0;
        b0 = nb0;
        r1 = nr1;
        a1 = na1;
        b1 = nb1;
    endtask

    // Short reset pulse kept inside the low clock phase; call right after a negedge.
    task automatic pulseReset();
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    // which: 0 ack0, 1 ack1, 2 g0, 3 g1, 4 any grant, 5 any ack
    task automatic waitFor(input int which, input int limit, input string name,
                           output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= limit && !ok; i++) begin
            @(negedge clk);
            n = i;
            case (which)
                0: ok = ack0;
                1: ok = ack1;
                2: ok = g0;
                3: ok = g1;
                4: ok = g0 | g1;
                default: ok = ack0 | ack1;
            endcase
        end
        if (!ok) checkOutput({name, " timeout"}, 0, 1);
    endtask

    // Reference model: an arbitration at edge k grants during k..k+1,
    // captures at k+1 with the ack during k+1..k+2, and the adder is free
    // again at k+3.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc        = 0;
            captureAt  = -1;
            freeAt     = 0;
            who        = 1'b0;
            lastServed = 1'b1;
            mG0 = 0; mG1 = 0; mAck0 = 0; mAck1 = 0; mBusy = 0;
            mY  = 0;
        end else begin
            cyc++;
            mG0 = 0; mG1 = 0; mAck0 = 0; mAck1 = 0;
            if (cyc == captureAt) begin
                if (who) mAck1 = 1; else mAck0 = 1;
                mY         = who ? (int'(a1) + int'(b1)) % MOD : (int'(a0) + int'(b0)) % MOD;
                mBusy      = 1;
                lastServed = who;
            end else if (cyc >= freeAt && (r0 || r1)) begin
                who = (r0 && r1) ? !lastServed : r1;
                if (who) mG1 = 1; else mG0 = 1;
                mBusy     = 1;
                captureAt = cyc + 1;
                freeAt    = cyc + 3;
            end else begin
                mBusy = 0;
            end
        end
    end

    // Every-cycle comparison against the model plus one-hot checks.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("g0", int'(g0), int'(mG0));
            checkOutput("g1", int'(g1), int'(mG1));
            checkOutput("ack0", int'(ack0), int'(mAck0));
            checkOutput("ack1", int'(ack1), int'(mAck1));
            checkOutput("busy", int'(busy), int'(mBusy));
            checkOutput("y", int'(y), mY);
            checkOutput("grantOneHot", int'(g0 & g1), 0);
            checkOutput("ackOneHot", int'(ack0 & ack1), 0);
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int n;
        bit ok;
        int cnt, misplaced, other;
        logic nr0, nr1;
        logic [W-1:0] na0, nb0, na1, nb1;

        // Reset with random inputs
        #3 reset = 1'b0;
        applyStimulus(1'($urandom_range(0, 1)), W'($urandom_range(0, MOD-1)), W'($urandom_range(0, MOD-1)),
                      1'($urandom_range(0, 1)), W'($urandom_range(0, MOD-1)), W'($urandom_range(0, MOD-1)));
        repeat (2) @(negedge clk);
        checkOn = 1'b1;
        checkOutput("reset g0", int'(g0), 0);
        checkOutput("reset g1", int'(g1), 0);
        checkOutput("reset ack0", int'(ack0), 0);
        checkOutput("reset ack1", int'(ack1), 0);
        checkOutput("reset y", int'(y), 0);
        checkOutput("reset busy", int'(busy), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;

        // Single request from port 0
        @(negedge clk);
        applyStimulus(1, 3, 4, 0, 0, 0);
        waitFor(2, 6, "t2 grant", n, ok);
        waitFor(0, 6, "t2 ack0", n, ok);
        if (ok) begin
            checkOutput("t2 y", int'(y), 7);
            checkOutput("t2 model y", mY, 7);
            checkOutput("t2 latency", n, 1);
        end
        applyStimulus(0, 3, 4, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("t2 y held", int'(y), 7);
        checkOutput("t2 idle busy", int'(busy), 0);

        // Both held: strict alternation starting with port 0
        pulseReset();
        applyStimulus(1, 1, 2, 1, 5, 6);
        waitFor(0, 8, "t3 first ack0", n, ok);
        if (ok) checkOutput("t3 y first", int'(y), 3);
        waitFor(1, 8, "t3 ack1", n, ok);
        if (ok) begin
            checkOutput("t3 ack1 spacing", n, 3);
            checkOutput("t3 y second", int'(y), 11);
        end
        waitFor(0, 8, "t3 second ack0", n, ok);
        if (ok) begin
            checkOutput("t3 ack0 spacing", n, 3);
            checkOutput("t3 y third", int'(y), 3);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Wrap without carry
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0, 1, 9, 9);
        waitFor(1, 8, "t4 ack1", n, ok);
        if (ok) checkOutput("t4 y wrap", int'(y), 2);
        applyStimulus(0, 0, 0, 0, 9, 9);

        // Reset while port 1 is granted
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0, 1, 7, 1);
        waitFor(3, 8, "t5 g1", n, ok);
        #1 reset = 1'b0;
        applyStimulus(1, 2, 2, 1, 7, 1);
        #1;
        checkOutput("t5 g1 cleared", int'(g1), 0);
        checkOutput("t5 y cleared", int'(y), 0);
        checkOutput("t5 busy cleared", int'(busy), 0);
        checkOutput("t5 ack1 none", int'(ack1), 0);
        #1 reset = 1'b1;
        waitFor(4, 8, "t5 first grant", n, ok);
        if (ok) checkOutput("t5 g0 first", int'(g0), 1);
        waitFor(5, 8, "t5 first ack", n, ok);
        if (ok) begin
            checkOutput("t5 ack0 first", int'(ack0), 1);
            checkOutput("t5 y", int'(y), 4);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Port 1 alone, held for several operations
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0, 1, 3, 2);
        waitFor(1, 8, "t6 first ack1", n, ok);
        cnt = 0;
        misplaced = 0;
        other = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack1) begin
                cnt++;
                if (i % 3 != 0) misplaced++;
            end
            if (g0 || ack0) other++;
        end
        checkOutput("t6 ack1 count", cnt, 4);
        checkOutput("t6 ack1 spacing", misplaced, 0);
        checkOutput("t6 port0 activity", other, 0);
        checkOutput("t6 y", int'(y), 5);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional violations and resets
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            nr0 = r0; na0 = a0; nb0 = b0;
            nr1 = r1; na1 = a1; nb1 = b1;
            if (ack0) begin
                nr0 = ($urandom_range(0, 3) == 0);
            end else if (!r0 && $urandom_range(0, 1) == 1) begin
                nr0 = 1'b1;
                na0 = W'($urandom_range(0, MOD-1));
                nb0 = W'($urandom_range(0, MOD-1));
            end
            if (ack1) begin
                nr1 = ($urandom_range(0, 3) == 0);
            end else if (!r1 && $urandom_range(0, 1) == 1) begin
                nr1 = 1'b1;
                na1 = W'($urandom_range(0, MOD-1));
                nb1 = W'($urandom_range(0, MOD-1));
            end
            if ($urandom_range(0, 19) == 0) na0 = W'($urandom_range(0, MOD-1));
            if ($urandom_range(0, 19) == 0) nb1 = W'($urandom_range(0, MOD-1));
            if ($urandom_range(0, 29) == 0) nr1 = ~nr1;
            applyStimulus(nr0, na0, nb0, nr1, na1, nb1);
            if ($urandom_range(0, 149) == 0) pulseReset();
        end

        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
